// File: rtl/l1_ahb_mtx_in_stage.sv
// -----------------------------------------------------------------------------
// l1_ahb_mtx_in_stage
//
// Per-master input stage of the L1 AHB bus matrix. There is one instance per
// slave interface (SI), placed directly upstream of that SI's address decoder.
//
// Normally the stage is a pure pass-through. When the master issues an
// address phase but the output stage is not yet serving this SI
// (active_dec low), the address phase is captured in a holding register.
// The master is then stalled until the held transfer has been issued
// downstream.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSELS..HAUSERS         address phase from the master
//   HREADYS                master-side HREADY (previous data phase done)
//   HREADYOUTS, HRESPS     ready / response returned to the master
//   sel_dec..auser_dec     current or held address phase to the decoder
//   ready_dec              HREADY presented to the decoder
//   active_dec             output stage is currently serving this SI
//   readyout_dec, resp_dec HREADYOUT / HRESP coming back from the decoder
//
// Handshake: an address phase is accepted when HSELS & HTRANSS[1] & HREADYS
// are all high on a rising HCLK edge. The stage completes a transfer towards
// the master only in a cycle where HREADYOUTS is high. While a transfer is
// held, HREADYOUTS stays low and all master inputs are ignored.
// -----------------------------------------------------------------------------
module l1_ahb_mtx_in_stage #(
  parameter int AW = 32,
  parameter int UW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSELS,
  input  logic [AW-1:0] HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic [2:0]    HBURSTS,
  input  logic [3:0]    HPROTS,
  input  logic [UW-1:0] HAUSERS,
  input  logic          HREADYS,
  output logic          HREADYOUTS,
  output logic [1:0]    HRESPS,
  output logic          sel_dec,
  output logic [AW-1:0] addr_dec,
  output logic [1:0]    trans_dec,
  output logic          write_dec,
  output logic [2:0]    size_dec,
  output logic [2:0]    burst_dec,
  output logic [3:0]    prot_dec,
  output logic [UW-1:0] auser_dec,
  output logic          ready_dec,
  input  logic          active_dec,
  input  logic          readyout_dec,
  input  logic [1:0]    resp_dec
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  logic          pend_tran_q,  pend_tran_d;
  logic [AW-1:0] reg_addr_q,   reg_addr_d;
  logic [1:0]    reg_trans_q,  reg_trans_d;
  logic          reg_write_q,  reg_write_d;
  logic [2:0]    reg_size_q,   reg_size_d;
  logic [2:0]    reg_burst_q,  reg_burst_d;
  logic [3:0]    reg_prot_q,   reg_prot_d;
  logic [UW-1:0] reg_auser_q,  reg_auser_d;

  logic valid_in;
  logic load;
  logic clear;

  always_comb begin
    valid_in = HSELS & HTRANSS[1] & HREADYS;
    load     = valid_in & ~active_dec & ~pend_tran_q;
    clear    = pend_tran_q & active_dec & readyout_dec;

    pend_tran_d = pend_tran_q;
    reg_addr_d  = reg_addr_q;
    reg_trans_d = reg_trans_q;
    reg_write_d = reg_write_q;
    reg_size_d  = reg_size_q;
    reg_burst_d = reg_burst_q;
    reg_prot_d  = reg_prot_q;
    reg_auser_d = reg_auser_q;

    if (clear) begin
      pend_tran_d = 1'b0;
    end else if (load) begin
      pend_tran_d = 1'b1;
      reg_addr_d  = HADDRS;
      // A held beat is reissued on its own after arbitration, so it always
      // starts a new burst: SEQ becomes NONSEQ, and any fixed-length burst
      // degrades to INCR because the original sequence may already be broken.
      reg_trans_d = TRANS_NONSEQ;
      reg_burst_d = (HBURSTS == BURST_SINGLE) ? BURST_SINGLE : BURST_INCR;
      reg_write_d = HWRITES;
      reg_size_d  = HSIZES;
      reg_prot_d  = HPROTS;
      reg_auser_d = HAUSERS;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_tran_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_trans_q <= '0;
      reg_write_q <= 1'b0;
      reg_size_q  <= '0;
      reg_burst_q <= '0;
      reg_prot_q  <= '0;
      reg_auser_q <= '0;
    end else begin
      pend_tran_q <= pend_tran_d;
      reg_addr_q  <= reg_addr_d;
      reg_trans_q <= reg_trans_d;
      reg_write_q <= reg_write_d;
      reg_size_q  <= reg_size_d;
      reg_burst_q <= reg_burst_d;
      reg_prot_q  <= reg_prot_d;
      reg_auser_q <= reg_auser_d;
    end
  end

  // Decoder side: held phase while pending, otherwise the live master phase.
  // While holding, the decoder's own HREADYOUT drives its HREADY so the held
  // phase is taken as soon as the previous downstream data phase finishes.
  always_comb begin
    if (pend_tran_q) begin
      sel_dec   = 1'b1;
      addr_dec  = reg_addr_q;
      trans_dec = reg_trans_q;
      write_dec = reg_write_q;
      size_dec  = reg_size_q;
      burst_dec = reg_burst_q;
      prot_dec  = reg_prot_q;
      auser_dec = reg_auser_q;
      ready_dec = readyout_dec;
    end else begin
      sel_dec   = HSELS;
      addr_dec  = HADDRS;
      trans_dec = HTRANSS;
      write_dec = HWRITES;
      size_dec  = HSIZES;
      burst_dec = HBURSTS;
      prot_dec  = HPROTS;
      auser_dec = HAUSERS;
      ready_dec = HREADYS;
    end
  end

  // Master side: stall with OKAY while a phase is held; the held transfer's
  // data phase is then answered straight from the decoder.
  always_comb begin
    HREADYOUTS = pend_tran_q ? 1'b0 : readyout_dec;
    HRESPS     = pend_tran_q ? RESP_OKAY : resp_dec;
  end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stage.sv
// -----------------------------------------------------------------------------
// tb_l1_ahb_mtx_in_stage
//
// Directed bench for l1_ahb_mtx_in_stage. Each table row is one HCLK cycle:
// the row's inputs are driven after the falling edge, the outputs are compared
// just before the next rising edge, and the hold state carries from row to
// row. The reset-mid-hold case is a hand-written sequence after the table.
// HSIZES/HPROTS/HAUSERS are derived from the address so that held and live
// phases are distinguishable on every control field.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l1_ahb_mtx_in_stage;

  localparam int AW = 32;
  localparam int UW = 32;

  // clock / reset
  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  // DUT connections
  logic          hsels;
  logic [AW-1:0] haddrs;
  logic [1:0]    htranss;
  logic          hwrites;
  logic [2:0]    hsizes;
  logic [2:0]    hbursts;
  logic [3:0]    hprots;
  logic [UW-1:0] hausers;
  logic          hreadys;
  logic          hreadyouts;
  logic [1:0]    hresps;
  logic          sel_dec;
  logic [AW-1:0] addr_dec;
  logic [1:0]    trans_dec;
  logic          write_dec;
  logic [2:0]    size_dec;
  logic [2:0]    burst_dec;
  logic [3:0]    prot_dec;
  logic [UW-1:0] auser_dec;
  logic          ready_dec;
  logic          active_dec;
  logic          readyout_dec;
  logic [1:0]    resp_dec;

  l1_ahb_mtx_in_stage #(.AW(AW), .UW(UW)) dut (
    .HCLK         (hclk),
    .HRESETn      (hresetn),
    .HSELS        (hsels),
    .HADDRS       (haddrs),
    .HTRANSS      (htranss),
    .HWRITES      (hwrites),
    .HSIZES       (hsizes),
    .HBURSTS      (hbursts),
    .HPROTS       (hprots),
    .HAUSERS      (hausers),
    .HREADYS      (hreadys),
    .HREADYOUTS   (hreadyouts),
    .HRESPS       (hresps),
    .sel_dec      (sel_dec),
    .addr_dec     (addr_dec),
    .trans_dec    (trans_dec),
    .write_dec    (write_dec),
    .size_dec     (size_dec),
    .burst_dec    (burst_dec),
    .prot_dec     (prot_dec),
    .auser_dec    (auser_dec),
    .ready_dec    (ready_dec),
    .active_dec   (active_dec),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec)
  );

  // {hreadyout, hresp, sel, addr, trans, write, size, burst, prot, auser, ready}
  localparam int OW = 1 + 2 + 1 + AW + 2 + 1 + 3 + 3 + 4 + UW + 1;

  typedef struct {
    logic          hsel;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hburst;
    logic          hready;
    logic          active;
    logic          readyout;
    logic [1:0]    resp;
    logic          e_hreadyout;
    logic [1:0]    e_hresp;
    logic          e_sel;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_trans;
    logic          e_write;
    logic [2:0]    e_burst;
    logic          e_ready;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  // Side-band control fields as a function of the address.
  function automatic logic [2:0] f_size(input logic [AW-1:0] a);
    return a[30:28];
  endfunction
  function automatic logic [3:0] f_prot(input logic [AW-1:0] a);
    return a[31:28] ^ 4'hf;
  endfunction
  function automatic logic [UW-1:0] f_auser(input logic [AW-1:0] a);
    return ~a;
  endfunction

  function automatic vec_t mk(
    input logic hsel, input logic [AW-1:0] haddr, input logic [1:0] htrans,
    input logic hwrite, input logic [2:0] hburst, input logic hready,
    input logic active, input logic readyout, input logic [1:0] resp,
    input logic e_hreadyout, input logic [1:0] e_hresp, input logic e_sel,
    input logic [AW-1:0] e_addr, input logic [1:0] e_trans, input logic e_write,
    input logic [2:0] e_burst, input logic e_ready);
    vec_t v;
    v.hsel = hsel; v.haddr = haddr; v.htrans = htrans; v.hwrite = hwrite;
    v.hburst = hburst; v.hready = hready; v.active = active;
    v.readyout = readyout; v.resp = resp;
    v.e_hreadyout = e_hreadyout; v.e_hresp = e_hresp; v.e_sel = e_sel;
    v.e_addr = e_addr; v.e_trans = e_trans; v.e_write = e_write;
    v.e_burst = e_burst; v.e_ready = e_ready;
    return v;
  endfunction

  // driver
  task automatic drive(input vec_t v);
    hsels        = v.hsel;
    haddrs       = v.haddr;
    htranss      = v.htrans;
    hwrites      = v.hwrite;
    hbursts      = v.hburst;
    hsizes       = f_size(v.haddr);
    hprots       = f_prot(v.haddr);
    hausers      = f_auser(v.haddr);
    hreadys      = v.hready;
    active_dec   = v.active;
    readyout_dec = v.readyout;
    resp_dec     = v.resp;
  endtask

  // scoreboard compare of the full output bundle
  task automatic check(input string name, input vec_t v);
    logic [OW-1:0] act;
    logic [OW-1:0] exp;
    act = {hreadyouts, hresps, sel_dec, addr_dec, trans_dec, write_dec,
           size_dec, burst_dec, prot_dec, auser_dec, ready_dec};
    exp = {v.e_hreadyout, v.e_hresp, v.e_sel, v.e_addr, v.e_trans, v.e_write,
           f_size(v.e_addr), v.e_burst, f_prot(v.e_addr), f_auser(v.e_addr),
           v.e_ready};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdyout=%b resp=%b sel=%b addr=%h trans=%b wr=%b size=%b burst=%b prot=%h auser=%h rdy=%b, want %h",
               name, hreadyouts, hresps, sel_dec, addr_dec, trans_dec, write_dec,
               size_dec, burst_dec, prot_dec, auser_dec, ready_dec, exp);
    end
  endtask

  task automatic step_check(input string name, input vec_t v);
    @(negedge hclk);
    drive(v);
    #2;
    check(name, v);
  endtask

  initial begin
    vec_t v;

    // ---------------- table ----------------
    //          hsel addr          trn  wr brst rdy act rdo rsp | hro hrsp sel addr          trn  wr brst rdy
    // idle, nothing selected
    vecs.push_back(mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 1, 0, 1, 2'b00, 1, 2'b00, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 1));
    // NONSEQ write, SI active: zero-latency pass-through
    vecs.push_back(mk(1, 32'h2000_0040, 2'b10, 1, 3'b000, 1, 1, 1, 2'b00, 1, 2'b00, 1, 32'h2000_0040, 2'b10, 1, 3'b000, 1));
    // its data phase: wait state with ERROR first cycle passes straight through
    vecs.push_back(mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 0, 1, 0, 2'b01, 0, 2'b01, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 0, 1, 1, 2'b01, 1, 2'b01, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 0));
    // NONSEQ read, SI not active: shown live this cycle, captured at the edge
    vecs.push_back(mk(1, 32'h6000_0000, 2'b10, 0, 3'b000, 1, 0, 1, 2'b00, 1, 2'b00, 1, 32'h6000_0000, 2'b10, 0, 3'b000, 1));
    // held: master moves to 0x1234_0000 write, decoder still sees the read
    vecs.push_back(mk(1, 32'h1234_0000, 2'b10, 1, 3'b000, 1, 0, 1, 2'b10, 0, 2'b00, 1, 32'h6000_0000, 2'b10, 0, 3'b000, 1));
    vecs.push_back(mk(1, 32'h1234_0000, 2'b10, 1, 3'b000, 1, 0, 0, 2'b11, 0, 2'b00, 1, 32'h6000_0000, 2'b10, 0, 3'b000, 0));
    // SI now active and ready: held phase issued, hold clears at this edge
    vecs.push_back(mk(1, 32'h1234_0000, 2'b10, 1, 3'b000, 1, 1, 1, 2'b00, 0, 2'b00, 1, 32'h6000_0000, 2'b10, 0, 3'b000, 1));
    // held read's data phase: decoder response returned to master
    vecs.push_back(mk(1, 32'h1234_0000, 2'b10, 1, 3'b000, 0, 1, 0, 2'b01, 0, 2'b01, 1, 32'h1234_0000, 2'b10, 1, 3'b000, 0));
    vecs.push_back(mk(1, 32'h1234_0000, 2'b10, 1, 3'b000, 0, 1, 1, 2'b01, 1, 2'b01, 1, 32'h1234_0000, 2'b10, 1, 3'b000, 0));
    vecs.push_back(mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 1, 1, 1, 2'b00, 1, 2'b00, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 1));
    // SEQ INCR4 beat, SI not active: captured as NONSEQ / INCR
    vecs.push_back(mk(1, 32'h5000_0004, 2'b11, 1, 3'b011, 1, 0, 1, 2'b00, 1, 2'b00, 1, 32'h5000_0004, 2'b11, 1, 3'b011, 1));
    vecs.push_back(mk(1, 32'h5000_0008, 2'b11, 1, 3'b011, 1, 0, 1, 2'b00, 0, 2'b00, 1, 32'h5000_0004, 2'b10, 1, 3'b001, 1));
    vecs.push_back(mk(1, 32'h5000_0008, 2'b11, 1, 3'b011, 1, 1, 1, 2'b00, 0, 2'b00, 1, 32'h5000_0004, 2'b10, 1, 3'b001, 1));
    vecs.push_back(mk(1, 32'h5000_0008, 2'b11, 1, 3'b011, 0, 1, 1, 2'b00, 1, 2'b00, 1, 32'h5000_0008, 2'b11, 1, 3'b011, 0));
    // IDLE, BUSY and unselected NONSEQ with SI inactive are never held
    vecs.push_back(mk(1, 32'h4000_0000, 2'b00, 0, 3'b000, 1, 0, 1, 2'b00, 1, 2'b00, 1, 32'h4000_0000, 2'b00, 0, 3'b000, 1));
    vecs.push_back(mk(1, 32'h4000_0010, 2'b01, 0, 3'b001, 1, 0, 1, 2'b00, 1, 2'b00, 1, 32'h4000_0010, 2'b01, 0, 3'b001, 1));
    vecs.push_back(mk(0, 32'h7000_0020, 2'b10, 0, 3'b000, 1, 0, 1, 2'b00, 1, 2'b00, 0, 32'h7000_0020, 2'b10, 0, 3'b000, 1));
    vecs.push_back(mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 1, 0, 1, 2'b00, 1, 2'b00, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 1));

    // ---------------- reset ----------------
    v = vecs[0];
    hresetn = 1'b0;
    drive(v);
    #2;
    check("reset_async", v);
    for (int i = 0; i < 3; i++) step_check($sformatf("reset_cyc%0d", i), v);
    @(negedge hclk);
    hresetn = 1'b1;
    #2;
    check("reset_release", v);

    // ---------------- table run ----------------
    for (int i = 0; i < vecs.size(); i++) step_check($sformatf("vec%0d", i), vecs[i]);

    // ---------------- reset mid-hold ----------------
    // WRAP8 NONSEQ captured while SI inactive
    step_check("rst_hold_load",
      mk(1, 32'h7000_0010, 2'b10, 1, 3'b100, 1, 0, 1, 2'b00, 1, 2'b00, 1, 32'h7000_0010, 2'b10, 1, 3'b100, 1));
    step_check("rst_hold_held",
      mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 1, 0, 1, 2'b00, 0, 2'b00, 1, 32'h7000_0010, 2'b10, 1, 3'b001, 1));
    // reset asserted mid-cycle: hold must vanish without a clock edge
    hresetn = 1'b0;
    #1;
    check("rst_hold_async",
      mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 1, 0, 1, 2'b00, 1, 2'b00, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 1));
    @(negedge hclk);
    hresetn = 1'b1;
    // new NONSEQ with SI active passes through with no hold
    step_check("rst_after_pass",
      mk(1, 32'h3000_0000, 2'b10, 0, 3'b000, 1, 1, 1, 2'b00, 1, 2'b00, 1, 32'h3000_0000, 2'b10, 0, 3'b000, 1));
    step_check("rst_after_idle",
      mk(0, 32'h0000_0000, 2'b00, 0, 3'b000, 1, 1, 1, 2'b00, 1, 2'b00, 0, 32'h0000_0000, 2'b00, 0, 3'b000, 1));

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_ahb_mtx_in_stage.md
Name: l1_ahb_mtx_in_stage

Overview:
- Per-master input stage of the L1 AHB bus matrix, one instance per slave interface (SI).
- Sits directly upstream of that SI's address decoder.
- Presents the current or held address phase to the decoder.
- Captures an address phase in a holding register when the selected output stage is not yet serving this SI (active_dec low), and stalls the master until the held transfer is issued.

Parameters:
- AW, 32, address width (decoder consumes addr_dec[AW-1:10]).
- UW, 32, HAUSER width.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSELS  in  1  SI select from master
- HADDRS  in  AW  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HAUSERS  in  UW  address user
- HREADYS  in  1  master-side HREADY
- HREADYOUTS  out  1  ready to master
- HRESPS  out  2  response to master
- sel_dec  out  1  select to decoder
- addr_dec  out  AW  address to decoder
- trans_dec  out  2  HTRANS to decoder
- write_dec, size_dec, burst_dec, prot_dec, auser_dec  out  1/3/3/4/UW  control to decoder
- ready_dec  out  1  HREADY to decoder
- active_dec  in  1  output stage serving this SI
- readyout_dec  in  1  HREADYOUT from decoder
- resp_dec  in  2  HRESP from decoder

Behaviour:
- Internal registers: pend_tran (1 bit) and the held field set reg_{addr, trans, write, size, burst, prot, auser}. All reset to 0.
- Outputs are combinational. At reset, pend_tran=0, so HREADYOUTS=readyout_dec and HRESPS=resp_dec.
- valid_in = HSELS & HTRANSS[1] & HREADYS, i.e. a NONSEQ or SEQ address phase accepted from the master.
- Load condition: valid_in & ~active_dec & ~pend_tran.
  - At the next HCLK edge, pend_tran<=1 and all fields are captured.
  - Held trans/burst conversion: SEQ is stored as NONSEQ. Burst INCR4/8/16 and WRAP4/8/16 are stored as INCR, because the burst may be broken by arbitration.
- Clear condition: pend_tran & active_dec & readyout_dec.
  - At that edge pend_tran<=0, and the held transfer's data phase begins.
  - If load and clear could coincide, clear wins; loading is impossible while pend_tran=1.
- Mux:
  - pend_tran=1: sel_dec=1, *_dec=reg_*, ready_dec=readyout_dec.
  - pend_tran=0: sel_dec=HSELS, *_dec=HS* (pass-through), ready_dec=HREADYS.
- Master handshake:
  - HREADYOUTS = pend_tran ? 0 : readyout_dec.
  - HRESPS = pend_tran ? OKAY(2'b00) : resp_dec.
- Master-side zero-latency path: when active_dec=1 at valid_in, there is no hold and no added cycle.
- Master is stalled exactly from the cycle after load through the cycle of clear, and then for the held transfer's own data-phase wait states.
- IDLE/BUSY transfers and HSELS=0 are never held.
- Master inputs are ignored while pend_tran=1. AHB requires the master to hold them stable anyway; any change has no effect.
- Reset mid-hold: pend_tran clears asynchronously and the held transfer is discarded. After release, the stage is pass-through.
- No X propagation: reg_* hold zeros until first load.

Test Plan:
- Reset, HSELS=0, readyout_dec=1 -> HREADYOUTS=1, HRESPS=00, sel_dec=0, pend_tran=0 on every cycle.
- NONSEQ write 0x2000_0040, active_dec=1 -> same cycle sel_dec=1, addr_dec=0x2000_0040, trans_dec=10. No hold; HREADYOUTS tracks readyout_dec.
- NONSEQ read 0x6000_0000, active_dec=0 for 3 cycles, then 1 with readyout_dec=1 -> pend_tran=1 from the next cycle. Over 3 cycles: HREADYOUTS=0, addr_dec=0x6000_0000 held while HADDRS is changed to 0x1234_0000. Then pend clears, and the following data phase returns resp_dec.
- SEQ INCR4 beat at 0x5000_0004 held -> trans_dec=10 (NONSEQ), burst_dec=001 (INCR), addr_dec=0x5000_0004.
- IDLE with HSELS=1 and active_dec=0 -> pend_tran stays 0, HREADYOUTS=readyout_dec.
- Hold set, HRESETn asserted mid-hold for 1 cycle -> pend_tran=0 immediately, sel_dec=HSELS. After release, a new NONSEQ passes through unheld with active_dec=1.
